// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder that reuses one digit add-and-adjust slice,
// least-significant digit first, with a start/busy/done handshake.
module bcd_serial_add_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic [4*DIGITS-1:0] a_i,
   input  logic [4*DIGITS-1:0] b_i,
   input  logic                cin_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [4*DIGITS-1:0] sum_o,
   output logic                cout_o,
   output logic                err_o
);
   localparam int W  = 4 * DIGITS;
   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, b_q, res_q, sum_q;
   logic [CW-1:0]   cnt_q;
   logic            carry_q, werr_q, cout_q, err_q;

   logic [4:0]      t;
   logic            gt9, nib_bad, last;
   logic [3:0]      dig;
   logic [W-1:0]    res_d;

   // Shared single-digit slice: operates on the low nibble of the shift registers.
   always_comb begin
      t       = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, carry_q};
      gt9     = (t > 5'd9);
      dig     = gt9 ? (t[3:0] + 4'd6) : t[3:0];
      nib_bad = (a_q[3:0] > 4'd9) || (b_q[3:0] > 4'd9);
      last    = (cnt_q == CW'(DIGITS - 1));
      res_d   = (res_q >> 4) | (W'(dig) << (W - 4));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = ADD;
         ADD:     if (last)    state_d = DONE;
         DONE:                 state_d = IDLE;
         default:              state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state_q != IDLE);
      done_o = (state_q == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         werr_q  <= 1'b0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start_i) begin
               a_q     <= a_i;
               b_q     <= b_i;
               carry_q <= cin_i;
               cnt_q   <= '0;
               werr_q  <= 1'b0;
            end
            ADD: begin
               a_q     <= a_q >> 4;
               b_q     <= b_q >> 4;
               carry_q <= gt9;
               res_q   <= res_d;
               werr_q  <= werr_q | nib_bad;
               cnt_q   <= cnt_q + 1'b1;
               // Visible results only move on the edge that enters DONE.
               if (last) begin
                  sum_q  <= res_d;
                  cout_q <= gt9;
                  err_q  <= werr_q | nib_bad;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum_o  = sum_q;
   assign cout_o = cout_q;
   assign err_o  = err_q;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl at DIGITS=4, 1 and 8: decimal-arithmetic
// reference model checked every cycle, plus hand-computed literal results.
module tb_bcd_serial_add_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int ND [3] = '{4, 1, 8};

   logic [31:0] a_in [3];
   logic [31:0] b_in [3];
   logic [2:0]  cin_in, st;
   logic [2:0]  busy_w, done_w, cout_w, err_w;
   logic [15:0] s0;
   logic [3:0]  s1;
   logic [31:0] s2;
   logic [31:0] sum_v [3];

   assign sum_v[0] = {16'b0, s0};
   assign sum_v[1] = {28'b0, s1};
   assign sum_v[2] = s2;

   bcd_serial_add_ctrl #(.DIGITS(4)) u_d4 (
      .clk(clk), .rst_n(rst_n), .start_i(st[0]), .a_i(a_in[0][15:0]), .b_i(b_in[0][15:0]),
      .cin_i(cin_in[0]), .busy_o(busy_w[0]), .done_o(done_w[0]), .sum_o(s0),
      .cout_o(cout_w[0]), .err_o(err_w[0]));
   bcd_serial_add_ctrl #(.DIGITS(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .start_i(st[1]), .a_i(a_in[1][3:0]), .b_i(b_in[1][3:0]),
      .cin_i(cin_in[1]), .busy_o(busy_w[1]), .done_o(done_w[1]), .sum_o(s1),
      .cout_o(cout_w[1]), .err_o(err_w[1]));
   bcd_serial_add_ctrl #(.DIGITS(8)) u_d8 (
      .clk(clk), .rst_n(rst_n), .start_i(st[2]), .a_i(a_in[2]), .b_i(b_in[2]),
      .cin_i(cin_in[2]), .busy_o(busy_w[2]), .done_o(done_w[2]), .sum_o(s2),
      .cout_o(cout_w[2]), .err_o(err_w[2]));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: {err, cout, sum}. Valid operands use plain decimal arithmetic;
   // invalid ones fall back to the per-digit adjust rule.
   function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic c, input int nd);
      logic        bad;
      longint      da, db, tot, p;
      logic [31:0] s;
      logic        co;
      int          ai, bi, t;
      bad = 1'b0; da = 0; db = 0; p = 1; s = '0; co = c;
      for (int i = nd - 1; i >= 0; i--) begin
         ai = int'(a[4*i +: 4]);
         bi = int'(b[4*i +: 4]);
         if (ai > 9 || bi > 9) bad = 1'b1;
         da = da * 10 + ai;
         db = db * 10 + bi;
         p  = p * 10;
      end
      if (!bad) begin
         tot = da + db + longint'(c);
         co  = (tot >= p);
         if (co) tot = tot - p;
         for (int i = 0; i < nd; i++) begin
            s[4*i +: 4] = 4'(tot % 10);
            tot = tot / 10;
         end
      end else begin
         for (int i = 0; i < nd; i++) begin
            t = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + int'(co);
            if (t > 9) begin s[4*i +: 4] = 4'(t + 6); co = 1'b1; end
            else begin s[4*i +: 4] = 4'(t); co = 1'b0; end
         end
      end
      return {bad, co, s};
   endfunction

   // Timeline model: ph=0 idle, 1..ND adding, ND+1 done pulse.
   int          ph [3] = '{0, 0, 0};
   logic [31:0] ma [3], mb [3], es [3] = '{0, 0, 0};
   logic        mc [3], ec [3] = '{0, 0, 0}, ee [3] = '{0, 0, 0};

   initial forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            ph[k] = 0; es[k] = '0; ec[k] = 1'b0; ee[k] = 1'b0;
         end else if (ph[k] == 0) begin
            if (st[k]) begin
               ma[k] = a_in[k]; mb[k] = b_in[k]; mc[k] = cin_in[k]; ph[k] = 1;
            end
         end else if (ph[k] <= ND[k]) begin
            if (ph[k] == ND[k]) {ee[k], ec[k], es[k]} = ref_add(ma[k], mb[k], mc[k], ND[k]);
            ph[k]++;
         end else begin
            ph[k] = 0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("busy[%0d]", k), 32'(busy_w[k]), 32'(ph[k] != 0));
         chk($sformatf("done[%0d]", k), 32'(done_w[k]), 32'(ph[k] == ND[k] + 1));
         chk($sformatf("sum[%0d]",  k), sum_v[k],       es[k]);
         chk($sformatf("cout[%0d]", k), 32'(cout_w[k]), 32'(ec[k]));
         chk($sformatf("err[%0d]",  k), 32'(err_w[k]),  32'(ee[k]));
      end
   end

   task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic c,
                         input logic [31:0] xs, input logic xc, input logic xe, input string nm);
      int  nbusy;
      bit  seen;
      @(negedge clk);
      a_in[k] = a; b_in[k] = b; cin_in[k] = c; st[k] = 1'b1;
      @(negedge clk);
      st[k] = 1'b0; a_in[k] = $urandom; b_in[k] = $urandom; cin_in[k] = 1'b1;
      seen = 0; nbusy = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
         if (busy_w[k]) nbusy++;
         if (done_w[k]) seen = 1;
         else @(negedge clk);
      end
      chk({nm, " done seen"}, 32'(seen), 32'd1);
      chk({nm, " sum"},  sum_v[k],       xs);
      chk({nm, " cout"}, 32'(cout_w[k]), 32'(xc));
      chk({nm, " err"},  32'(err_w[k]),  32'(xe));
      chk({nm, " busy cycles"}, 32'(nbusy), 32'(ND[k] + 1));
      @(negedge clk);
      chk({nm, " done width"}, 32'(done_w[k]), 32'd0);
   endtask

   initial begin
      int nd;
      st = '0; cin_in = '0;
      for (int k = 0; k < 3; k++) begin a_in[k] = '0; b_in[k] = '0; end
      repeat (3) @(negedge clk);
      chk("reset busy", 32'(busy_w), 32'd0);
      chk("reset done", 32'(done_w), 32'd0);
      chk("reset sum0", sum_v[0], 32'd0);
      chk("reset cout", 32'(cout_w), 32'd0);
      chk("reset err",  32'(err_w),  32'd0);
      rst_n = 1'b1;

      run_op(0, 32'h1234, 32'h5678, 1'b0, 32'h6912, 1'b0, 1'b0, "d4 1234+5678");
      run_op(0, 32'h9999, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0, "d4 9999+0001");
      run_op(0, 32'h9999, 32'h9999, 1'b1, 32'h9999, 1'b1, 1'b0, "d4 9999+9999+1");
      run_op(0, 32'h00A0, 32'h0000, 1'b0, 32'h0100, 1'b0, 1'b1, "d4 invalid 00A0");
      run_op(0, 32'h0001, 32'h0001, 1'b0, 32'h0002, 1'b0, 1'b0, "d4 err clears");

      // Start pulses during ADD and DONE must be ignored.
      @(negedge clk);
      a_in[0] = 32'h1111; b_in[0] = 32'h2222; cin_in[0] = 1'b0; st[0] = 1'b1;
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         st[0] = (i == 1 || i == 3 || i == 4);
         if (done_w[0]) nd++;
      end
      chk("ignored start done count", 32'(nd), 32'd1);
      chk("ignored start sum", sum_v[0], 32'h3333);

      // Held start relaunches every DIGITS+2 cycles.
      a_in[0] = 32'h0005; b_in[0] = 32'h0004; st[0] = 1'b1;
      nd = 0;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (done_w[0]) nd++;
      end
      st[0] = 1'b0;
      chk("held start done count", 32'(nd), 32'd3);
      chk("held start sum", sum_v[0], 32'h0009);
      repeat (8) @(negedge clk);

      // Reset two edges into an operation aborts it.
      a_in[0] = 32'h1234; b_in[0] = 32'h1111; st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort busy", 32'(busy_w[0]), 32'd0);
      chk("abort done", 32'(done_w[0]), 32'd0);
      chk("abort sum",  sum_v[0], 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done_w[0]) nd++;
      end
      chk("abort no done", 32'(nd), 32'd0);
      run_op(0, 32'h0450, 32'h0550, 1'b0, 32'h1000, 1'b0, 1'b0, "d4 after abort");

      run_op(1, 32'h9, 32'h9, 1'b1, 32'h9, 1'b1, 1'b0, "d1 9+9+1");
      run_op(1, 32'h9, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, "d1 9+1");
      run_op(1, 32'h3, 32'h4, 1'b0, 32'h7, 1'b0, 1'b0, "d1 3+4");
      run_op(2, 32'h99999999, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, "d8 ripple");
      run_op(2, 32'h99999999, 32'h99999999, 1'b1, 32'h99999999, 1'b1, 1'b0, "d8 max");
      run_op(2, 32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0, "d8 no carry");
      run_op(2, 32'hF0000000, 32'h00000000, 1'b0, 32'h50000000, 1'b1, 1'b1, "d8 invalid top");

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
